// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Types and constants shared by the instruction fetch front-end:
//               FSM state encoding, fetch buffer entry and the NOP word shown
//               on the core interface when the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // Canonical RISC-V NOP (addi x0, x0, 0)
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // One buffered fetch: the instruction word and the address it came from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the instruction-memory handshake (req/gnt/rvalid)
//               and the core-side handshake (valid/ready, redirect, halt).
//               master = fetch unit, slave = memory + core environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

    // Instruction memory side
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // Core side
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_gnt, mem_rvalid, mem_rdata, inst_ready, redirect, redirect_pc, halt
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries. Head is read straight from
//               register storage. Flush takes precedence over push; push and
//               pop together are accepted even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push_i,
    input  wire fetch_entry_t           push_data_i,
    input  wire logic                   pop_i,
    input  wire logic                   flush_i,
    output fetch_entry_t                head_o,
    output logic                        valid_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic           w_do_pop;
    logic           w_do_push;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push
    assign w_do_pop  = pop_i && (count_q != '0);
    assign w_do_push = push_i && ((count_q != DEPTH_C) || w_do_pop);

    // Pointer and occupancy bookkeeping; flush empties the FIFO outright
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{(CW-1){1'b0}}, w_do_push} - {{(CW-1){1'b0}}, w_do_pop};
        end
    end

    // Entry storage; contents need no reset because count_q gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front-end. Holds the fetch PC, issues one
//               outstanding word request at a time to a variable-latency
//               instruction memory and buffers responses for the core.
//               Redirects flush the buffer and discard any in-flight fetch.
//               Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall
//               counters as extra output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fetch_unit_if.master    bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e   state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    req_addr_q, req_addr_d;

    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;
    logic           w_head_valid;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_after;
    logic           w_push;
    logic           w_pop;
    logic           w_room;
    logic [31:0]    w_redirect_pc;

    // Only a response to a live (non-dropped) request is buffered; a redirect
    // in the same cycle voids both the response and any consume
    assign w_push        = (state_q == WAIT) && bus.mem_rvalid && !bus.redirect;
    assign w_pop         = w_head_valid && bus.inst_ready && !bus.redirect;
    assign w_push_entry  = '{inst: bus.mem_rdata, pc: req_addr_q};
    assign w_redirect_pc = word_align(bus.redirect_pc);

    // Room for another request once this cycle's push/pop have landed
    assign w_count_after = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    assign w_room        = (w_count_after < DEPTH_C);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (bus.redirect),
        .head_o      (w_head),
        .valid_o     (w_head_valid),
        .count_o     (w_count)
    );

    // Sequencer state, fetch PC and address of the outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state logic: normal sequencing first, then redirect overrides it
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;

        case (state_q)
            IDLE: begin
                // Nothing is outstanding here, so occupancy alone decides
                if (!bus.halt && (w_count < DEPTH_C)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_d    = WAIT;
                    req_addr_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d = (w_room && !bus.halt) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.mem_rvalid) begin
                    state_d = bus.halt ? IDLE : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.redirect) begin
            fetch_pc_d = w_redirect_pc;
            req_addr_d = req_addr_q;
            case (state_q)
                IDLE: begin
                    state_d = bus.halt ? IDLE : REQ;
                end
                REQ: begin
                    // Ungranted request simply retargets; a granted one must be drained
                    state_d = bus.mem_gnt ? DROP : REQ;
                end
                WAIT, DROP: begin
                    // A response arriving now is the one being discarded
                    if (bus.mem_rvalid) begin
                        state_d = bus.halt ? IDLE : REQ;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req    = (state_q == REQ);
    assign bus.mem_addr   = fetch_pc_q;
    assign bus.inst_valid = w_head_valid;
    assign bus.inst       = w_head_valid ? w_head.inst : INST_NOP;
    assign bus.inst_pc    = w_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Count buffered fetches and cycles where the core waited on an empty buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (w_push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bus.inst_ready && !w_head_valid && !bus.redirect) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed, table-driven bench for fetch_unit (DEPTH=2,
//               RESET_PC=0). Each table row lists the outputs expected in a
//               cycle and the memory/core inputs applied in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 29;
    vec_t vt [NV];

    function automatic vec_t V(logic g, logic rv, logic [31:0] rd, logic rdy, logic rdr,
                               logic [31:0] rpc, logic er, logic [31:0] ea, logic eiv,
                               logic [31:0] ei, logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redir = rdr; v.rpc = rpc;
        v.e_req = er; v.e_addr = ea; v.e_iv = eiv; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdr, input logic [31:0] rpc, input logic h);
        rst                 = r;
        bus.mem_gnt         = g;
        bus.mem_rvalid      = rv;
        bus.mem_rdata       = rd;
        bus.inst_ready      = rdy;
        bus.redirect        = rdr;
        bus.redirect_pc     = rpc;
        bus.halt            = h;
    endtask

    task automatic check_out(input string tag, input logic er, input logic [31:0] ea,
                             input logic eiv, input logic [31:0] ei, input logic [31:0] ep);
        check({tag, ".mem_req"},    {31'd0, bus.mem_req},    {31'd0, er});
        check({tag, ".mem_addr"},   bus.mem_addr,            ea);
        check({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, eiv});
        check({tag, ".inst"},       bus.inst,                ei);
        if (eiv) check({tag, ".inst_pc"}, bus.inst_pc, ep);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Normal streaming, back-pressure, redirects, PC wrap
        vt[0]  = V(0,0,32'h0,             1,0,32'h0,         0,32'h0,        0,INST_NOP,     32'h0);
        vt[1]  = V(1,0,32'h0,             1,0,32'h0,         1,32'h0,        0,INST_NOP,     32'h0);
        vt[2]  = V(0,1,32'h1000_0000,     1,0,32'h0,         0,32'h4,        0,INST_NOP,     32'h0);
        vt[3]  = V(1,0,32'h0,             1,0,32'h0,         1,32'h4,        1,32'h1000_0000,32'h0);
        vt[4]  = V(0,1,32'h1000_0004,     1,0,32'h0,         0,32'h8,        0,INST_NOP,     32'h0);
        vt[5]  = V(1,0,32'h0,             1,0,32'h0,         1,32'h8,        1,32'h1000_0004,32'h4);
        vt[6]  = V(0,1,32'h1000_0008,     1,0,32'h0,         0,32'hC,        0,INST_NOP,     32'h0);
        vt[7]  = V(1,0,32'h0,             0,0,32'h0,         1,32'hC,        1,32'h1000_0008,32'h8);
        vt[8]  = V(0,1,32'h1000_000C,     0,0,32'h0,         0,32'h10,       1,32'h1000_0008,32'h8);
        vt[9]  = V(0,0,32'h0,             0,0,32'h0,         0,32'h10,       1,32'h1000_0008,32'h8);
        vt[10] = V(0,0,32'h0,             0,0,32'h0,         0,32'h10,       1,32'h1000_0008,32'h8);
        vt[11] = V(0,0,32'h0,             1,0,32'h0,         0,32'h10,       1,32'h1000_0008,32'h8);
        vt[12] = V(0,0,32'h0,             0,0,32'h0,         0,32'h10,       1,32'h1000_000C,32'hC);
        vt[13] = V(1,0,32'h0,             0,0,32'h0,         1,32'h10,       1,32'h1000_000C,32'hC);
        vt[14] = V(0,0,32'h0,             1,1,32'h103,       0,32'h14,       1,32'h1000_000C,32'hC);
        vt[15] = V(0,1,32'h1000_0010,     1,0,32'h0,         0,32'h100,      0,INST_NOP,     32'h0);
        vt[16] = V(1,0,32'h0,             1,0,32'h0,         1,32'h100,      0,INST_NOP,     32'h0);
        vt[17] = V(0,1,32'h1000_0100,     1,0,32'h0,         0,32'h104,      0,INST_NOP,     32'h0);
        vt[18] = V(0,0,32'h0,             0,1,32'h200,       1,32'h104,      1,32'h1000_0100,32'h100);
        vt[19] = V(1,0,32'h0,             1,0,32'h0,         1,32'h200,      0,INST_NOP,     32'h0);
        vt[20] = V(0,1,32'h1000_0200,     1,0,32'h0,         0,32'h204,      0,INST_NOP,     32'h0);
        vt[21] = V(1,0,32'h0,             0,0,32'h0,         1,32'h204,      1,32'h1000_0200,32'h200);
        vt[22] = V(0,1,32'h1000_0204,     1,1,32'hFFFF_FFFC, 0,32'h208,      1,32'h1000_0200,32'h200);
        vt[23] = V(1,0,32'h0,             1,0,32'h0,         1,32'hFFFF_FFFC,0,INST_NOP,     32'h0);
        vt[24] = V(0,1,32'hDEAD_BEEF,     1,0,32'h0,         0,32'h0,        0,INST_NOP,     32'h0);
        vt[25] = V(1,0,32'h0,             1,0,32'h0,         1,32'h0,        1,32'hDEAD_BEEF,32'hFFFF_FFFC);
        vt[26] = V(0,1,32'h1234_5678,     1,0,32'h0,         0,32'h4,        0,INST_NOP,     32'h0);
        vt[27] = V(0,0,32'h0,             1,0,32'h0,         1,32'h4,        1,32'h1234_5678,32'h0);
        vt[28] = V(0,0,32'h0,             0,0,32'h0,         1,32'h4,        0,INST_NOP,     32'h0);

        drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            check_out($sformatf("v%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_iv,
                      vt[i].e_inst, vt[i].e_pc);
            drive(0, vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].ready, vt[i].redir, vt[i].rpc, 0);
            @(negedge clk);
        end

        // Reset during WAIT: fetch restarts at RESET_PC and a late response is ignored
        drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check_out("rst_wait", 0, 32'h8, 0, INST_NOP, 32'h0);
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check_out("rst_idle", 0, 32'h0, 0, INST_NOP, 32'h0);
        drive(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check_out("rst_late", 1, 32'h0, 0, INST_NOP, 32'h0);
        drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check_out("rst_wait2", 0, 32'h4, 0, INST_NOP, 32'h0);

        // Halt: the outstanding response still lands, but no new request issues
        drive(0, 0, 1, 32'h0000_0055, 0, 0, 32'h0, 1);
        @(negedge clk);
        check_out("halt_push", 0, 32'h4, 1, 32'h0000_0055, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
        @(negedge clk);
        check_out("halt_hold", 0, 32'h4, 1, 32'h0000_0055, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        check_out("halt_release", 1, 32'h4, 1, 32'h0000_0055, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
